// File: rtl/sc64.sv
// Shared sc64 system constants plus the uart_rx state encoding and a 3-input majority helper.
package sc64;
    localparam int CLOCK_FREQUENCY = 100_000_000;
    localparam int UART_BAUD_RATE  = 1_000_000;

    typedef enum bit [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} e_uart_rx_state;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_if.sv
// Receive holding-register handshake between uart_rx (master) and the CPU-side UART peripheral (slave).
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_filter.sv
// RXD synchronizer followed by a 3-sample majority filter; clean edges reach filt after exactly 4 clocks.
module uart_rx_filter
    import sc64::*;
(
    input  logic clk,
    input  logic reset,
    input  logic uart_rxd,
    output logic filt
);
    logic s1_q, s2_q, h0_q, h1_q, filt_q;
    logic s1_d, s2_d, h0_d, h1_d, filt_d;

    always_comb begin
        s1_d   = uart_rxd;
        s2_d   = s1_q;
        h0_d   = s2_q;
        h1_d   = h0_q;
        filt_d = majority3(s2_q, h0_q, h1_q);
    end

    // Resetting to low keeps a line held low across reset from looking like a fresh start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            h0_q   <= 1'b0;
            h1_q   <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            h0_q   <= h0_d;
            h1_q   <= h1_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready holding register and frame_error/overrun pulses.
// Define UART_RX_FLOW_CONTROL_EN to drive uart_rts from the holding-register occupancy.
module uart_rx
    import sc64::*;
#(
    parameter int CLOCK_FREQUENCY = sc64::CLOCK_FREQUENCY,
    parameter int BAUD_RATE       = sc64::UART_BAUD_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    uart_rx_if.master  rx,
    output logic       frame_error,
    output logic       overrun,
    output logic       uart_rts
);
    // state     | meaning
    // WAIT_IDLE | after reset or framing error: wait for a real high line
    // IDLE      | armed, waiting for a falling edge
    // START     | timing to start-bit midpoint; high there is a false start
    // DATA      | sampling 8 data bits, LSB first
    // STOP      | sampling stop bit; deliver or flag framing error
    localparam int DIV = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);

    if (DIV < 8) begin : g_div_check
        $error("uart_rx: CLOCK_FREQUENCY / BAUD_RATE must be at least 8");
    end

    logic filt;

    uart_rx_filter u_filter (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (uart_rxd),
        .filt     (filt)
    );

    e_uart_rx_state state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bitidx_q, bitidx_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           frame_error_q, frame_error_d;
    logic           overrun_q, overrun_d;
    logic           deliver;
    logic           consume;

    assign consume = rx_valid_q & rx.rx_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bitidx_d      = bitidx_q;
        shreg_d       = shreg_q;
        deliver       = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            WAIT_IDLE: begin
                if (filt) state_d = IDLE;
            end
            IDLE: begin
                if (!filt) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!filt) begin
                    state_d  = DATA;
                    cnt_d    = CNT_FULL;
                    bitidx_d = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shreg_d  = {filt, shreg_q[7:1]};
                    cnt_d    = CNT_FULL;
                    bitidx_d = bitidx_q + 3'd1;
                    if (bitidx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (filt) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end else begin
                    frame_error_d = 1'b1;
                    state_d       = WAIT_IDLE;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    // A delivery may reuse the slot freed by a same-edge consume; otherwise a full slot drops the new byte.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~consume;
        overrun_d  = 1'b0;
        if (deliver) begin
            if (!rx_valid_q || consume) begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_IDLE;
            cnt_q         <= '0;
            bitidx_q      <= 3'd0;
            shreg_q       <= 8'd0;
            rx_data_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bitidx_q      <= bitidx_d;
            shreg_q       <= shreg_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx.rx_data  = rx_data_q;
    assign rx.rx_valid = rx_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

`ifdef UART_RX_FLOW_CONTROL_EN
    logic rts_q, rts_d;

    assign rts_d = rx_valid_q;

    always_ff @(posedge clk) begin
        if (reset) rts_q <= 1'b0;
        else       rts_q <= rts_d;
    end

    assign uart_rts = rts_q;
`else
    assign uart_rts = 1'b0;
`endif
endmodule
